agc_mct_sequencer: RTL and testbench

Instruction-cycle sequencer for the AGC simulator core. Divides the master clock into 12-phase memory cycle times (MCTs, TP1..TP12) and alternates fetch and execute MCTs. Owns the program counter, issues instruction reads to memory, loads the 15-bit instruction register, and strobes the instruction fetch/decode unit through its `tp` input. Hands control to the execute datapath and stalls the pulse train on slow memory or execute handshakes.

---
 rtl/agc_pkg.sv | 20 ++
 rtl/agc_mct_sequencer_if.sv | 25 ++
 rtl/agc_tp_gen.sv | 23 ++
 rtl/agc_mct_sequencer.sv | 137 +++++++++++++
 tb/tb_agc_mct_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/agc_pkg.sv
// Shared types and constants for the AGC instruction-cycle sequencer.
package agc_pkg;

    localparam int unsigned INSTR_W  = 15;
    localparam int unsigned TP_N     = 12;
    localparam logic [11:0] RESET_PC = 12'h800;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        FAULT = 2'd3
    } seq_state_t;

    // Bit positions of the timing pulses within the one-hot tp vector.
    typedef enum int unsigned {
        TP1 = 0, TP2, TP3, TP4, TP5, TP6, TP7, TP8, TP9, TP10, TP11, TP12
    } tp_idx_t;

endpackage

// File: rtl/agc_mct_sequencer_if.sv
// Memory read and execute-datapath handshakes of the sequencer.
interface agc_mct_sequencer_if #(
    parameter int unsigned ADDR_W = 12
);

    logic                         mem_req;
    logic [ADDR_W-1:0]            mem_addr;
    logic                         mem_ack;
    logic [agc_pkg::INSTR_W-1:0]  mem_rdata;
    logic                         exec_start;
    logic                         exec_done;
    logic                         branch_valid;
    logic [ADDR_W-1:0]            branch_target;

    modport master (
        output mem_req, mem_addr, exec_start,
        input  mem_ack, mem_rdata, exec_done, branch_valid, branch_target
    );

    modport slave (
        input  mem_req, mem_addr, exec_start,
        output mem_ack, mem_rdata, exec_done, branch_valid, branch_target
    );

endinterface

// File: rtl/agc_tp_gen.sv
// Twelve-phase one-hot timing-pulse ring with start, hold and clear controls.
module agc_tp_gen
    import agc_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            hold,
    input  logic            clear,
    output logic [TP_N-1:0] tp
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            tp <= '0;
        end else if (start) begin
            tp <= TP_N'(1);
        end else if (!hold) begin
            tp <= {tp[TP_N-2:0], tp[TP_N-1]};
        end
    end

endmodule

// File: rtl/agc_mct_sequencer.sv
// Fetch/execute MCT sequencer: owns PC and IR, drives memory reads and
// the execute handshake, and stalls the timing ring on slow responses.
module agc_mct_sequencer
    import agc_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(agc_pkg::RESET_PC),
    parameter int unsigned       MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    output logic [TP_N-1:0]      tp,
    output logic                 mct_done,
    output logic [ADDR_W-1:0]    pc,
    output logic [INSTR_W-1:0]   ir,
    output logic                 decode_strobe,
    output logic [1:0]           seq_state,
    output logic                 fault,
    agc_mct_sequencer_if.master  bus
);

    localparam int unsigned       CNT_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(MEM_TIMEOUT - 1);

    seq_state_t        state, state_nxt;
    logic              got_ack, done_seen, br_valid;
    logic [ADDR_W-1:0] br_target;
    logic [CNT_W-1:0]  stall_cnt;
    logic              in_fetch, in_exec, ack_now, done_now;
    logic              mem_stall, exec_stall, timeout;
    logic              tp_start, tp_hold, tp_clear;

    assign in_fetch = (state == FETCH);
    assign in_exec  = (state == EXEC);

    assign bus.mem_req    = in_fetch && !got_ack;
    assign bus.mem_addr   = bus.mem_req ? pc : '0;
    assign bus.exec_start = in_exec && tp[TP1];

    assign ack_now  = bus.mem_req && bus.mem_ack;
    assign done_now = in_exec && !done_seen && bus.exec_done;

    // A held TP4 cycle is one with the read still outstanding and no ack now;
    // the MEM_TIMEOUT-th such cycle faults instead of holding again.
    assign mem_stall  = bus.mem_req && !bus.mem_ack && tp[TP4];
    assign timeout    = mem_stall && (stall_cnt == STALL_LAST);
    assign exec_stall = in_exec && tp[TP11] && !done_seen && !bus.exec_done;

    assign decode_strobe = in_fetch && tp[TP6];
    assign mct_done      = tp[TP12];
    assign seq_state     = state;
    assign fault         = (state == FAULT);

    always_comb begin
        state_nxt = state;
        tp_start  = 1'b0;
        tp_clear  = 1'b0;
        tp_hold   = (mem_stall && !timeout) || exec_stall;
        unique case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = FETCH;
                    tp_start  = 1'b1;
                end
            end
            FETCH: begin
                if (timeout) begin
                    state_nxt = FAULT;
                    tp_clear  = 1'b1;
                end else if (tp[TP12]) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (tp[TP12]) begin
                    if (run) begin
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = IDLE;
                        tp_clear  = 1'b1;
                    end
                end
            end
            FAULT: state_nxt = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            got_ack   <= 1'b0;
            done_seen <= 1'b0;
            br_valid  <= 1'b0;
            br_target <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (ack_now) begin
                ir        <= bus.mem_rdata;
                got_ack   <= 1'b1;
                stall_cnt <= '0;
            end else if (mem_stall) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (done_now) begin
                done_seen <= 1'b1;
                br_valid  <= bus.branch_valid;
                br_target <= bus.branch_target;
            end
            if (in_fetch && tp[TP6]) begin
                pc <= pc + 1'b1;
            end
            if (tp[TP12]) begin
                got_ack   <= 1'b0;
                done_seen <= 1'b0;
                br_valid  <= 1'b0;
                stall_cnt <= '0;
                if (in_exec && br_valid) begin
                    pc <= br_target;
                end
            end
        end
    end

    agc_tp_gen u_tp_gen (
        .clk   (clk),
        .reset (reset),
        .start (tp_start),
        .hold  (tp_hold),
        .clear (tp_clear),
        .tp    (tp)
    );

endmodule

// File: tb/tb_agc_mct_sequencer.sv
// Bench for agc_mct_sequencer: directed and randomized instructions checked
// against cycle-count arithmetic derived from the MCT timing rules.
module tb_agc_mct_sequencer;
    import agc_pkg::*;

    localparam int unsigned AW  = 12;
    localparam int unsigned TMO = 15;
    localparam logic [AW-1:0] RPC = 12'h800;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              run = 1'b0;
    logic [11:0]       tp;
    logic              mct_done;
    logic [AW-1:0]     pc;
    logic [14:0]       ir;
    logic              decode_strobe;
    logic [1:0]        seq_state;
    logic              fault;
    int                errors = 0;
    int                checks = 0;
    logic [AW-1:0]     exp_pc;

    always #5 clk = ~clk;

    agc_mct_sequencer_if #(.ADDR_W(AW)) bus ();

    agc_mct_sequencer #(
        .ADDR_W      (AW),
        .RESET_PC    (RPC),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .tp            (tp),
        .mct_done      (mct_done),
        .pc            (pc),
        .ir            (ir),
        .decode_strobe (decode_strobe),
        .seq_state     (seq_state),
        .fault         (fault),
        .bus           (bus.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Phase number (1..12) at MCT cycle c when the ring waits at hold_at for stall cycles.
    function automatic int phase_of(input int c, input int hold_at, input int stall);
        if (c <= hold_at) return c;
        if (c <= hold_at + stall) return hold_at;
        return c - stall;
    endfunction

    function automatic logic [11:0] onehot(input int p);
        logic [11:0] v;
        v = '0;
        v[p-1] = 1'b1;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.mem_ack       = 1'b0;
        bus.mem_rdata     = '0;
        bus.exec_done     = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b0;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        chk("rst_tp", 32'(tp), 32'd0);
        chk("rst_pc", 32'(pc), 32'(RPC));
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_state", 32'(seq_state), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_strobe", 32'(decode_strobe), 32'd0);
        chk("rst_xstart", 32'(bus.exec_start), 32'd0);
        chk("rst_mctdone", 32'(mct_done), 32'd0);
    endtask

    task automatic check_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("idle_state", 32'(seq_state), 32'd0);
            chk("idle_tp", 32'(tp), 32'd0);
            chk("idle_req", 32'(bus.mem_req), 32'd0);
            chk("idle_pc", 32'(pc), 32'(exp_pc));
        end
    endtask

    // One fetch+execute instruction. Called at the negedge before the
    // FETCH-TP1 posedge; returns at the negedge of EXEC TP12 (or after reset).
    task automatic do_instr(input int ack_cyc, input logic [14:0] data, input int done_cyc,
                            input bit bv, input logic [AW-1:0] bt, input bit keep_run,
                            input int rst_at);
        int sf, se, flen, elen, p;
        logic [AW-1:0] pc0, pc_inc;
        pc0    = exp_pc;
        pc_inc = pc0 + 1'b1;
        sf     = (ack_cyc > 4) ? ack_cyc - 4 : 0;
        se     = (done_cyc > 11) ? done_cyc - 11 : 0;
        flen   = 12 + sf;
        elen   = 12 + se;
        for (int c = 1; c <= flen; c++) begin
            @(negedge clk);
            p = phase_of(c, 4, sf);
            chk("fetch_tp", 32'(tp), 32'(onehot(p)));
            chk("fetch_state", 32'(seq_state), 32'd1);
            chk("fetch_fault", 32'(fault), 32'd0);
            chk("fetch_req", 32'(bus.mem_req), 32'(c <= ack_cyc));
            if (c <= ack_cyc) chk("fetch_addr", 32'(bus.mem_addr), 32'(pc0));
            chk("decode_strobe", 32'(decode_strobe), 32'(p == 6));
            chk("fetch_mct_done", 32'(mct_done), 32'(p == 12));
            chk("fetch_pc", 32'(pc), 32'((c > 6 + sf) ? pc_inc : pc0));
            if (c > ack_cyc) chk("fetch_ir", 32'(ir), 32'(data));
            if (c == 3) run = keep_run;
            bus.exec_done    = 1'b0;
            bus.branch_valid = 1'($urandom);
            bus.mem_ack      = (c == ack_cyc) || (c == ack_cyc + 2);
            bus.mem_rdata    = (c == ack_cyc) ? data : 15'($urandom);
        end
        for (int c = 1; c <= elen; c++) begin
            @(negedge clk);
            p = phase_of(c, 11, se);
            chk("exec_tp", 32'(tp), 32'(onehot(p)));
            chk("exec_state", 32'(seq_state), 32'd2);
            chk("exec_start", 32'(bus.exec_start), 32'(p == 1));
            chk("exec_mct_done", 32'(mct_done), 32'(p == 12));
            chk("exec_req", 32'(bus.mem_req), 32'd0);
            chk("exec_pc", 32'(pc), 32'(pc_inc));
            if (rst_at != 0 && c == rst_at) begin
                reset = 1'b1;
                break;
            end
            bus.mem_ack       = 1'($urandom);
            bus.mem_rdata     = 15'($urandom);
            bus.exec_done     = (c == done_cyc) || (c == done_cyc + 1);
            bus.branch_valid  = (c == done_cyc) ? bv : ((c == done_cyc + 1) ? 1'b1 : 1'($urandom));
            bus.branch_target = (c == done_cyc) ? bt : ~bt;
        end
        if (rst_at != 0) begin
            @(negedge clk);
            reset = 1'b0;
            idle_inputs();
            chk("midrst_pc", 32'(pc), 32'(RPC));
            chk("midrst_tp", 32'(tp), 32'd0);
            chk("midrst_state", 32'(seq_state), 32'd0);
            chk("midrst_ir", 32'(ir), 32'd0);
            exp_pc = RPC;
        end else begin
            exp_pc = bv ? bt : pc_inc;
        end
    endtask

    initial begin
        idle_inputs();
        do_reset();
        exp_pc = RPC;
        check_idle(2);

        // Basic instruction: ack at TP2, execute done at TP5, no branch.
        run = 1'b1;
        do_instr(2, 15'o65421, 5, 1'b0, 12'h000, 1'b1, 0);
        // Ack 5 cycles past TP4 (29-cycle instruction), branch to 0x123 at EXEC TP5.
        do_instr(9, 15'($urandom), 5, 1'b1, 12'h123, 1'b1, 0);
        // Branch to top of memory, then fetch there with exec_done withheld past TP11.
        do_instr(3, 15'($urandom), 4, 1'b1, 12'hFFF, 1'b1, 0);
        do_instr(1, 15'($urandom), 14, 1'b0, 12'h000, 1'b1, 0);
        // Ack on the last stalled cycle before timeout: no fault.
        do_instr(4 + TMO - 1, 15'($urandom), 11, 1'b0, 12'h000, 1'b1, 0);

        for (int n = 0; n < 24; n++) begin
            do_instr(int'($urandom_range(1, 12)), 15'($urandom), int'($urandom_range(1, 14)),
                     1'($urandom), 12'($urandom), 1'b1, 0);
        end

        // run dropped during FETCH TP3: finish the instruction, then idle.
        do_instr(2, 15'($urandom), 6, 1'b0, 12'h000, 1'b0, 0);
        check_idle(3);

        // Reset during EXEC TP7, then restart from the reset PC.
        run = 1'b1;
        do_instr(1, 15'($urandom), 3, 1'b1, 12'h456, 1'b1, 7);
        do_instr(2, 15'($urandom), 8, 1'b0, 12'h000, 1'b0, 0);
        check_idle(2);

        // Memory never acks: fault after TMO stalled cycles, sticky until reset.
        do_reset();
        run = 1'b1;
        for (int c = 1; c <= 4 + TMO + 3; c++) begin
            @(negedge clk);
            if (c <= 3 + TMO) begin
                chk("tmo_tp", 32'(tp), 32'(onehot((c < 4) ? c : 4)));
                chk("tmo_req", 32'(bus.mem_req), 32'd1);
                chk("tmo_fault_low", 32'(fault), 32'd0);
            end else begin
                chk("tmo_state", 32'(seq_state), 32'd3);
                chk("tmo_fault", 32'(fault), 32'd1);
                chk("tmo_tp_zero", 32'(tp), 32'd0);
                chk("tmo_req_low", 32'(bus.mem_req), 32'd0);
            end
            bus.mem_ack = (c > 3 + TMO);
        end
        do_reset();
        exp_pc = RPC;
        check_idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
